// File: rtl/sd_cmd_ctrl_if.sv
// Bundle of the CMD-engine signals: host handshake (start/index/arg, done/resp/flags)
// and the CMD pad pair. master = controller/pad side, slave = sd_cmd_ctrl.
interface sd_cmd_ctrl_if;
  logic        istart;
  logic [5:0]  iindex;
  logic [31:0] iarg;
  logic        icmd;
  logic        ocmd;
  logic        ocmd_oe;
  logic        odone;
  logic [31:0] oresp;
  logic        otimeout;
  logic        ocrc_err;

  modport master (
    output istart, iindex, iarg, icmd,
    input  ocmd, ocmd_oe, odone, oresp, otimeout, ocrc_err
  );

  modport slave (
    input  istart, iindex, iarg, icmd,
    output ocmd, ocmd_oe, odone, oresp, otimeout, ocrc_err
  );
endinterface

// File: rtl/sd_cmd_ctrl.sv
// SD CMD-line engine: sends a 48-bit command with CRC7, receives and checks the response.
// Macro SD_CMD_CRC_CHECK_EN enables the receive CRC7 / end-bit check.
module sd_cmd_ctrl #(
  parameter int unsigned NCR_MAX = 64,
  parameter int unsigned NRC     = 8
) (
  input  logic        iclk,
  input  logic        irst_n,
  sd_cmd_ctrl_if.slave bus
);

  localparam int unsigned CNT_MAX = (NCR_MAX > 136) ? NCR_MAX : 136;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_TX_DATA   = CW'(40);
  localparam logic [CW-1:0] C_TX_LAST   = CW'(47);
  localparam logic [CW-1:0] C_RX_DATA   = CW'(40);
  localparam logic [CW-1:0] C_R48_LAST  = CW'(47);
  localparam logic [CW-1:0] C_R136_LAST = CW'(135);
  localparam logic [CW-1:0] C_WAIT_LAST = CW'(NCR_MAX - 1);
  localparam logic [CW-1:0] C_GAP_LAST  = CW'(NRC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_GAP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_R1,
    RSP_R2,
    RSP_R3
  } rsp_t;

  // Serial CRC7, polynomial x^7 + x^3 + 1
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [5:0]    idx_q;
  logic [39:0]   tx_sh_q;
  logic [6:0]    tx_crc_q;
  logic [38:0]   rx_sh_q;
  logic [31:0]   resp_q;
  logic          timeout_q;
  rsp_t          rsp;
  logic [CW-1:0] rx_last;
  logic          tx_bit;
  logic          rx_fail;

  always_comb begin
    case (idx_q)
      6'd15:        rsp = RSP_NONE;
      6'd2, 6'd9:   rsp = RSP_R2;
      6'd41:        rsp = RSP_R3;
      default:      rsp = RSP_R1;
    endcase
  end

  assign rx_last = (rsp == RSP_R2) ? C_R136_LAST : C_R48_LAST;

  always_comb begin
    if (cnt_q < C_TX_DATA)      tx_bit = tx_sh_q[39];
    else if (cnt_q < C_TX_LAST) tx_bit = tx_crc_q[6];
    else                        tx_bit = 1'b1;
  end

`ifdef SD_CMD_CRC_CHECK_EN
  logic [6:0] rx_crc_q;
  logic       crc_err_q;

  // Evaluated on the last bit: rx_sh_q[6:0] then holds the received CRC field
  always_comb begin
    rx_fail = !bus.icmd || ((rsp == RSP_R1) && (rx_sh_q[6:0] != rx_crc_q));
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      rx_crc_q  <= '0;
      crc_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.istart) crc_err_q <= 1'b0;
        S_WAIT: if (!bus.icmd) rx_crc_q <= '0;
        S_RECV: begin
          if (cnt_q < C_RX_DATA) rx_crc_q <= crc7_step(rx_crc_q, bus.icmd);
          if (cnt_q == rx_last && rx_fail) crc_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ocrc_err = crc_err_q;
`else
  assign rx_fail      = 1'b0;
  assign bus.ocrc_err = 1'b0;
`endif

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.ocmd    = 1'b1;
    bus.ocmd_oe = 1'b0;
    bus.odone   = 1'b0;
    case (state_q)
      S_IDLE: if (bus.istart) state_d = S_SEND;
      S_SEND: begin
        bus.ocmd_oe = 1'b1;
        bus.ocmd    = tx_bit;
        if (cnt_q == C_TX_LAST) state_d = (rsp == RSP_NONE) ? S_GAP : S_WAIT;
      end
      S_WAIT: begin
        if (!bus.icmd)                state_d = S_RECV;
        else if (cnt_q == C_WAIT_LAST) state_d = S_GAP;
      end
      S_RECV: if (cnt_q == rx_last) state_d = S_GAP;
      S_GAP:  if (cnt_q == C_GAP_LAST) state_d = S_DONE;
      S_DONE: begin
        bus.odone = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_sh_q   <= '0;
      tx_crc_q  <= '0;
      rx_sh_q   <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.istart) begin
            idx_q     <= bus.iindex;
            tx_sh_q   <= {2'b01, bus.iindex, bus.iarg};
            tx_crc_q  <= '0;
            cnt_q     <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
          end
        end
        S_SEND: begin
          cnt_q <= (cnt_q == C_TX_LAST) ? '0 : cnt_q + CW'(1);
          if (cnt_q < C_TX_DATA) begin
            tx_crc_q <= crc7_step(tx_crc_q, tx_sh_q[39]);
            tx_sh_q  <= {tx_sh_q[38:0], 1'b0};
          end else begin
            tx_crc_q <= {tx_crc_q[5:0], 1'b0};
          end
        end
        S_WAIT: begin
          // The start bit is checked first so it wins over a simultaneous timeout
          if (!bus.icmd) begin
            cnt_q   <= CW'(1);
            rx_sh_q <= '0;
          end else if (cnt_q == C_WAIT_LAST) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            resp_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RECV: begin
          rx_sh_q <= {rx_sh_q[37:0], bus.icmd};
          if (cnt_q == rx_last) begin
            cnt_q  <= '0;
            resp_q <= rx_fail ? '0 : rx_sh_q[38:7];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_GAP:   cnt_q <= cnt_q + CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.oresp    = resp_q;
  assign bus.otimeout = timeout_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl: command framing, response capture, timeout,
// CRC/end-bit errors (build-dependent), R2 length, ignored starts and mid-frame reset.
module tb_sd_cmd_ctrl;

  logic iclk = 1'b0;
  logic irst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 iclk = ~iclk;

  sd_cmd_ctrl_if bus ();

  sd_cmd_ctrl #(.NCR_MAX(64), .NRC(8)) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC7 by polynomial long division (x^7+x^3+1 -> 8'h89)
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  // Issues one command and plays the card: response frame starts rdelay cycles after
  // the command ends (cycle 49). Cycle 0 is the istart cycle.
  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg,
                        input int rdelay, input int rlen, input logic [135:0] rframe,
                        input int stray_at,
                        output logic [47:0] txf, output int oe_cnt,
                        output int done_at, output int ndone);
    int j;
    txf = '0; oe_cnt = 0; done_at = -1; ndone = 0;
    @(negedge iclk);
    bus.istart = 1'b1; bus.iindex = idx; bus.iarg = arg; bus.icmd = 1'b1;
    for (int c = 1; c < 400; c++) begin
      @(negedge iclk);
      bus.istart = (c == stray_at);
      bus.iindex = (c == stray_at) ? 6'd15 : idx;
      if (bus.ocmd_oe) begin
        txf = {txf[46:0], bus.ocmd};
        oe_cnt++;
      end
      if (bus.odone) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      j = c - 49 - rdelay;
      if (rlen > 0 && j >= 0 && j < rlen) bus.icmd = rframe[rlen - 1 - j];
      else                                bus.icmd = 1'b1;
      if (done_at >= 0 && c >= done_at + 3) break;
    end
    bus.istart = 1'b0;
  endtask

  logic [47:0]  txf;
  int           oe_cnt, done_at, ndone;
  logic [47:0]  r1, r1_bad, r3, r3_bad;
  logic [135:0] r2;
  logic [119:0] cid;

  initial begin
    irst_n     = 1'b0;
    bus.istart = 1'b0;
    bus.iindex = '0;
    bus.iarg   = '0;
    bus.icmd   = 1'b1;

    r1     = {8'h37, 32'h0000_0120, ref_crc7({8'h37, 32'h0000_0120}), 1'b1};
    r1_bad = r1 ^ 48'h0000_0000_0004;
    r3     = {8'h3F, 32'h80FF_8000, 7'h7F, 1'b1};
    r3_bad = {8'h3F, 32'h80FF_8000, 7'h7F, 1'b0};
    cid    = 120'h0123456789ABCDEF001122DEADBEEF;
    r2     = {8'h3F, cid, 7'h55, 1'b1};

    repeat (3) @(negedge iclk);
    chk("rst_ocmd",    bus.ocmd,     1);
    chk("rst_oe",      bus.ocmd_oe,  0);
    chk("rst_done",    bus.odone,    0);
    chk("rst_resp",    bus.oresp,    0);
    chk("rst_timeout", bus.otimeout, 0);
    chk("rst_crcerr",  bus.ocrc_err, 0);
    @(negedge iclk);
    irst_n = 1'b1;

    // CMD8, card silent: frame check plus timeout path
    do_cmd(6'd8, 32'h0000_01AA, 0, 0, '0, -1, txf, oe_cnt, done_at, ndone);
    chk("cmd8_frame",   txf,          48'h48000001AA87);
    chk("cmd8_oe",      oe_cnt,       48);
    chk("cmd8_done_at", done_at,      121);
    chk("cmd8_ndone",   ndone,        1);
    chk("cmd8_timeout", bus.otimeout, 1);
    chk("cmd8_resp",    bus.oresp,    0);

    // CMD55 with good R1 after 10 idle clocks
    do_cmd(6'd55, 32'h0, 10, 48, {88'b0, r1}, -1, txf, oe_cnt, done_at, ndone);
    chk("cmd55_frame",   txf,          48'h770000000065);
    chk("cmd55_oe",      oe_cnt,       48);
    chk("cmd55_done_at", done_at,      115);
    chk("cmd55_ndone",   ndone,        1);
    chk("cmd55_resp",    bus.oresp,    32'h0000_0120);
    chk("cmd55_timeout", bus.otimeout, 0);
    chk("cmd55_crcerr",  bus.ocrc_err, 0);

    // CMD15: no response; a start pulse in the DONE cycle must be ignored
    do_cmd(6'd15, 32'h1234_5678, 0, 0, '0, 57, txf, oe_cnt, done_at, ndone);
    chk("cmd15_done_at", done_at,      57);
    chk("cmd15_oe",      oe_cnt,       48);
    chk("cmd15_ndone",   ndone,        1);
    chk("cmd15_timeout", bus.otimeout, 0);
    chk("cmd15_crcerr",  bus.ocrc_err, 0);

    // CMD3, card silent
    do_cmd(6'd3, 32'h0, 0, 0, '0, -1, txf, oe_cnt, done_at, ndone);
    chk("cmd3_done_at", done_at,      121);
    chk("cmd3_timeout", bus.otimeout, 1);
    chk("cmd3_resp",    bus.oresp,    0);

    // CMD55 with a flipped CRC bit
    do_cmd(6'd55, 32'h0, 0, 48, {88'b0, r1_bad}, -1, txf, oe_cnt, done_at, ndone);
    chk("crcbad_done_at", done_at, 105);
    chk("crcbad_timeout", bus.otimeout, 0);
`ifdef SD_CMD_CRC_CHECK_EN
    chk("crcbad_crcerr", bus.ocrc_err, 1);
    chk("crcbad_resp",   bus.oresp,    0);
`else
    chk("crcbad_crcerr", bus.ocrc_err, 0);
    chk("crcbad_resp",   bus.oresp,    32'h0000_0120);
`endif

    // CMD41 R3: CRC field not checked
    do_cmd(6'd41, 32'h40FF_8000, 0, 48, {88'b0, r3}, -1, txf, oe_cnt, done_at, ndone);
    chk("r3_done_at", done_at,      105);
    chk("r3_resp",    bus.oresp,    32'h80FF_8000);
    chk("r3_crcerr",  bus.ocrc_err, 0);

    // CMD41 R3 with end bit 0
    do_cmd(6'd41, 32'h40FF_8000, 0, 48, {88'b0, r3_bad}, -1, txf, oe_cnt, done_at, ndone);
`ifdef SD_CMD_CRC_CHECK_EN
    chk("endbit_crcerr", bus.ocrc_err, 1);
    chk("endbit_resp",   bus.oresp,    0);
`else
    chk("endbit_crcerr", bus.ocrc_err, 0);
    chk("endbit_resp",   bus.oresp,    32'h80FF_8000);
`endif

    // CMD2 R2 136-bit; a start pulse during WAIT must be ignored
    do_cmd(6'd2, 32'h0, 2, 136, r2, 50, txf, oe_cnt, done_at, ndone);
    chk("r2_done_at", done_at,      195);
    chk("r2_ndone",   ndone,        1);
    chk("r2_oe",      oe_cnt,       48);
    chk("r2_resp",    bus.oresp,    32'hDEAD_BEEF);
    chk("r2_crcerr",  bus.ocrc_err, 0);
    chk("r2_timeout", bus.otimeout, 0);

    // Reset in the middle of SEND
    @(negedge iclk);
    bus.istart = 1'b1; bus.iindex = 6'd8; bus.iarg = 32'h0000_01AA;
    @(negedge iclk);
    bus.istart = 1'b0;
    repeat (20) @(negedge iclk);
    chk("midrst_pre_oe", bus.ocmd_oe, 1);
    #2 irst_n = 1'b0;
    #1;
    chk("midrst_oe",   bus.ocmd_oe, 0);
    chk("midrst_ocmd", bus.ocmd,    1);
    chk("midrst_resp", bus.oresp,   0);
    @(negedge iclk);
    irst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge iclk);
      if (bus.odone) ndone++;
    end
    chk("midrst_ndone", ndone, 0);

    // Recovery after reset
    do_cmd(6'd15, 32'h0, 0, 0, '0, -1, txf, oe_cnt, done_at, ndone);
    chk("recover_done_at", done_at, 57);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
